// File: rtl/boot_copier_if.sv
// boot_copier_if: handshake bundle between the boot copier and its flash/RAM controllers.
// Ports (copier view): i_start, i_flash_done, i_flash_data, i_ram_done in;
// o_flash_req, o_flash_addr, o_ram_req, o_ram_addr, o_ram_data, o_busy, o_boot_done, o_boot_err, o_words_copied out.
interface boot_copier_if #(
    parameter int unsigned FLASH_AW = 22,
    parameter int unsigned RAM_AW   = 18,
    parameter int unsigned DW       = 16
);
    logic                i_start;
    logic                i_flash_done;
    logic [DW-1:0]       i_flash_data;
    logic                i_ram_done;
    logic                o_flash_req;
    logic [FLASH_AW:1]   o_flash_addr;
    logic                o_ram_req;
    logic [RAM_AW-1:0]   o_ram_addr;
    logic [DW-1:0]       o_ram_data;
    logic                o_busy;
    logic                o_boot_done;
    logic                o_boot_err;
    logic [15:0]         o_words_copied;
    modport master (
        input  i_start, i_flash_done, i_flash_data, i_ram_done,
        output o_flash_req, o_flash_addr, o_ram_req, o_ram_addr, o_ram_data,
               o_busy, o_boot_done, o_boot_err, o_words_copied
    );
    modport slave (
        output i_start, i_flash_done, i_flash_data, i_ram_done,
        input  o_flash_req, o_flash_addr, o_ram_req, o_ram_addr, o_ram_data,
               o_busy, o_boot_done, o_boot_err, o_words_copied
    );
endinterface

// File: rtl/boot_copier.sv
// boot_copier: copies a boot image from flash into RAM, optionally length-prefixed and checksummed.
// Ports: clk; rst (synchronous, active-low); bus (master side of boot_copier_if carrying
// start, the flash/RAM request-done handshakes and the busy/done/error/progress status).
module boot_copier #(
    parameter int unsigned FLASH_AW   = 22,
    parameter int unsigned RAM_AW     = 18,
    parameter int unsigned DW         = 16,
    parameter int unsigned FLASH_BASE = 1,
    parameter int unsigned RAM_BASE   = 0,
    parameter int unsigned WORDS      = 'h21A,
    parameter int unsigned MAX_WORDS  = 'h1000,
    parameter int unsigned HDR_EN     = 0,
    parameter int unsigned AUTO_START = 1
) (
    input logic           clk,
    input logic           rst,
    boot_copier_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, RD, WR, SUM, DONE, ERR} state_t;
    state_t            r_state;
    logic              r_first;
    logic [15:0]       r_cnt;
    logic [DW-1:0]     r_len;
    logic [DW-1:0]     r_sum;
    logic [DW-1:0]     r_ram_data;
    logic [FLASH_AW:1] r_flash_addr;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              r_flash_req;
    logic              r_ram_req;
    logic              r_busy;
    logic              r_boot_done;
    logic              r_boot_err;
    logic [15:0]       w_next;
    logic              w_last;
    logic              w_go;
    assign w_next = r_cnt + 16'd1;
    assign w_last = 32'(w_next) == 32'(r_len);
    // AUTO_START acts as a start pulse on the first cycle out of reset
    assign w_go = (r_state == IDLE || r_state == DONE || r_state == ERR) &&
                  (bus.i_start || (AUTO_START != 0 && r_first));
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_first      <= 1'b1;
            r_cnt        <= '0;
            r_len        <= '0;
            r_sum        <= '0;
            r_ram_data   <= '0;
            r_flash_addr <= FLASH_AW'(FLASH_BASE);
            r_ram_addr   <= RAM_AW'(RAM_BASE);
            r_flash_req  <= 1'b0;
            r_ram_req    <= 1'b0;
            r_busy       <= 1'b0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
        end else begin
            r_first <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: if (w_go) begin
                    // header and payload word 0 both sit at FLASH_BASE relative to the first read
                    r_state      <= (HDR_EN != 0) ? HDR : RD;
                    r_flash_addr <= FLASH_AW'(FLASH_BASE);
                    r_flash_req  <= 1'b1;
                    r_busy       <= 1'b1;
                    r_boot_done  <= 1'b0;
                    r_boot_err   <= 1'b0;
                    r_cnt        <= '0;
                    r_sum        <= '0;
                    r_len        <= (HDR_EN != 0) ? '0 : DW'(WORDS);
                end
                HDR: if (bus.i_flash_done) begin
                    r_len        <= bus.i_flash_data;
                    // first payload word and the checksum of an empty image share this address
                    r_flash_addr <= FLASH_AW'(FLASH_BASE + 1);
                    if (32'(bus.i_flash_data) > MAX_WORDS) begin
                        r_state     <= ERR;
                        r_flash_req <= 1'b0;
                        r_busy      <= 1'b0;
                        r_boot_err  <= 1'b1;
                    end else begin
                        r_state <= (bus.i_flash_data == '0) ? SUM : RD;
                    end
                end
                RD: if (bus.i_flash_done) begin
                    r_state     <= WR;
                    r_flash_req <= 1'b0;
                    r_ram_req   <= 1'b1;
                    r_ram_data  <= bus.i_flash_data;
                    r_ram_addr  <= RAM_AW'(RAM_BASE + 32'(r_cnt));
                    r_sum       <= r_sum + bus.i_flash_data;
                end
                WR: if (bus.i_ram_done) begin
                    r_ram_req <= 1'b0;
                    r_cnt     <= w_next;
                    if (w_last && HDR_EN == 0) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_boot_done <= 1'b1;
                    end else begin
                        r_state      <= w_last ? SUM : RD;
                        r_flash_req  <= 1'b1;
                        r_flash_addr <= w_last ? FLASH_AW'(FLASH_BASE + 1 + 32'(r_len))
                                               : FLASH_AW'(FLASH_BASE + HDR_EN + 32'(w_next));
                    end
                end
                SUM: if (bus.i_flash_done) begin
                    r_state     <= (bus.i_flash_data == r_sum) ? DONE : ERR;
                    r_flash_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_boot_done <= bus.i_flash_data == r_sum;
                    r_boot_err  <= bus.i_flash_data != r_sum;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_flash_req    = r_flash_req;
    assign bus.o_flash_addr   = r_flash_addr;
    assign bus.o_ram_req      = r_ram_req;
    assign bus.o_ram_addr     = r_ram_addr;
    assign bus.o_ram_data     = r_ram_data;
    assign bus.o_busy         = r_busy;
    assign bus.o_boot_done    = r_boot_done;
    assign bus.o_boot_err     = r_boot_err;
    assign bus.o_words_copied = r_cnt;
endmodule

// File: doc/boot_copier.md
# boot_copier

Parametrised flash-to-SRAM boot loader, successor to the fixed-length single-image copier. After reset or a `start` pulse, it copies a program image word by word from flash into RAM. It uses the same request/done handshakes with the flash and RAM controllers. An optional header/checksum mode reads the image length from flash and verifies the image before releasing the CPU. `boot_done` gates CPU fetch; `boot_err` reports a bad image.

## Interface
- `FLASH_AW`, 22: flash word-address width (`flash_addr[FLASH_AW:1]`).
- `RAM_AW`, 18: RAM address width.
- `DW`, 16: data width.
- `FLASH_BASE`, 1: flash word address of the image (or of its header).
- `RAM_BASE`, 0: RAM destination of payload word 0.
- `WORDS`, 'h21A: payload length when `HDR_EN`=0.
- `MAX_WORDS`, 'h1000: largest length accepted from a header.
- `HDR_EN`, 0: 1 = header/checksum mode.
- `AUTO_START`, 1: 1 = start copying on the first cycle out of reset.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: one-cycle pulse; (re)starts a boot from IDLE, DONE or ERR.
- `flash_done`, in, 1: one-cycle pulse; `flash_data` valid this cycle.
- `flash_data`, in, DW: flash read data.
- `ram_done`, in, 1: one-cycle pulse; RAM write complete.
- `flash_req`, out, 1: read request, held until `flash_done`.
- `flash_addr`, out, FLASH_AW (bits `[FLASH_AW:1]`): read address.
- `ram_req`, out, 1: write request, held until `ram_done`.
- `ram_addr`, out, RAM_AW: write address.
- `ram_data`, out, DW: write data.
- `busy`, out, 1: copy in progress.
- `boot_done`, out, 1: image loaded (and verified if `HDR_EN`=1).
- `boot_err`, out, 1: header length invalid or checksum mismatch.
- `words_copied`, out, 16: payload words written so far.

## Operation
- States:
  - **IDLE**: wait for `start`.
  - **HDR**: read the length word.
  - **RD**: read a payload word.
  - **WR**: write it to RAM.
  - **SUM**: read the checksum word.
  - **DONE**.
  - **ERR**.
- Start:
  - If `AUTO_START`=1, the first cycle after reset enters HDR (`HDR_EN`=1) or RD (`HDR_EN`=0).
  - Otherwise the block stays in IDLE until `start`.
  - `start` in DONE/ERR clears `boot_done`/`boot_err`/`words_copied` and starts the same way. `start` in any other state is ignored.
- HDR: read `FLASH_BASE`. On `flash_done`, latch length L = `flash_data`.
  - L > `MAX_WORDS` → ERR.
  - L = 0 → SUM.
  - Otherwise → RD.
- Length: when `HDR_EN`=0, L = `WORDS` and SUM is never entered.
- RD, word i: `flash_addr` = `FLASH_BASE` + `HDR_EN` + i, truncated to `FLASH_AW`. On `flash_done`, latch `ram_data` ← `flash_data`, `ram_addr` ← (`RAM_BASE` + i) mod 2^`RAM_AW`, add the word to the DW-bit running sum (mod 2^DW), then → WR.
- WR: on `ram_done`, increment i and `words_copied`.
  - i = L → SUM (`HDR_EN`=1) or DONE (`HDR_EN`=0).
  - Otherwise → RD.
- SUM: read `FLASH_BASE` + 1 + L. On `flash_done`:
  - `flash_data` == running sum → DONE.
  - Otherwise → ERR.
- DONE: `boot_done`=1. ERR: `boot_err`=1, `boot_done` stays 0. Both states hold until `start` or reset.
- Stray or mismatched pulses: `flash_done` outside HDR/RD/SUM and `ram_done` outside WR are ignored. A simultaneous `flash_done`+`ram_done` is resolved by the current state only.
- Reset values: `flash_req`, `ram_req`, `busy`, `boot_done`, `boot_err` = 0; `flash_addr` = `FLASH_BASE`; `ram_addr` = `RAM_BASE`; `ram_data`, `words_copied`, running sum = 0.
- Reset mid-copy: both requests drop at the next edge, all state returns to reset values, and the partial RAM contents are not restored.

## Timing
- `flash_req` rises on the edge that enters HDR/RD/SUM.
- It falls on the edge that samples `flash_done`. `ram_req` rises on that same edge, with `ram_addr`/`ram_data` valid at the same edge.
- `ram_req` falls on the edge sampling `ram_done`. The next `flash_req` (if any) rises on that same edge: zero idle cycles between transfers.
- Addresses and data are stable for the whole time a request is high.
- `busy` = 1 in HDR/RD/WR/SUM.
- `boot_done` and `boot_err` rise on the edge that enters DONE or ERR. They are registered and glitch-free.
- Overhead: 0 cycles beyond the controller latencies. Total = Σ flash latency + Σ RAM latency + 1 cycle (AUTO_START entry).

## Test plan
- **Default parameters, fixed-latency models (flash 3 cycles, RAM 2 cycles):**
  - Expect 0x21A words copied, flash 1..0x21A → RAM 0..0x219.
  - `boot_done` rises immediately after the 0x21A-th `ram_done`.
  - No request overlap; `words_copied` = 0x21A.
- **`HDR_EN`=1, flash holds length 4, data 1,2,3,4, checksum 10:**
  - RAM 0..3 = 1..4; `boot_done`=1, `boot_err`=0.
  - Repeat with checksum 11: RAM still written, `boot_err`=1, `boot_done`=0.
- **`HDR_EN`=1, header 0x2000 > `MAX_WORDS`:** ERR after exactly one flash read, with no `ram_req` ever.
- **Header 0, checksum word 0:** DONE with zero RAM writes. Then pulse `start`: the boot reruns and status clears on the following edge.
- **Reset mid-copy, with a stray `ram_done` during RD and a `start` pulse while busy:**
  - Assert `rst`=0 while `ram_req` is high at word 5: all outputs take reset values next edge, then a fresh copy from word 0.
  - The stray `ram_done` and the `start` pulse both have no effect.
- **`RAM_BASE` = 2^18−2, L = 4:** writes land at 0x3FFFE, 0x3FFFF, 0x0, 0x1, and `flash_addr` increments linearly.
